// File: rtl/accel_spi_reader_if.sv
// Signal bundle between the ADXL345 X-axis reader and its consumer/board pins.
// The slave modport is the reader itself; master is the side that drives enable and MISO.
interface accel_spi_reader_if;
    logic       enable;
    logic       spi_miso;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic [9:0] a_num;
    logic       a_valid;
    logic       init_done;
    logic       busy;

    modport master (
        output enable, spi_miso,
        input  spi_cs_n, spi_sclk, spi_mosi, a_num, a_valid, init_done, busy
    );

    modport slave (
        input  enable, spi_miso,
        output spi_cs_n, spi_sclk, spi_mosi, a_num, a_valid, init_done, busy
    );
endinterface

// File: rtl/accel_spi_reader.sv
// SPI mode-3 master that configures an ADXL345 and periodically reads the 10-bit X sample.
// Optional macro ACCEL_AVG_EN: report the running mean of the last four samples instead of raw.
module accel_spi_reader #(
    parameter int CLK_DIV    = 25,
    parameter int SAMPLE_DIV = 500000,
    parameter int CS_GAP     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    accel_spi_reader_if.slave    bus
);
    localparam int DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int DIV_W   = $clog2(DIV_MAX) + 1;
    localparam int CNT_W   = $clog2(SAMPLE_DIV) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_FMT, S_INIT_PWR, S_WAIT_TICK, S_READ_X, S_UPDATE
    } state_t;

    typedef enum logic [2:0] {
        E_IDLE, E_LEAD, E_LOW, E_HIGH, E_TAIL, E_GAP
    } eng_t;

    state_t           state_q, state_d;
    logic             launched_q, launched_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    eng_t             eng_q, eng_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bits_q, bits_d;
    logic [23:0]      tx_q, tx_d;
    logic [9:0]       rx_q, rx_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;
    logic             div_last;

    logic             start;
    logic [23:0]      start_word;
    logic [4:0]       start_bits;

    logic [9:0]       raw_x;
    logic [9:0]       a_num_q, a_num_d;
    logic             a_valid_q, a_valid_d;
    logic             init_done_q;

    assign tick     = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // ---------------- control FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            launched_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            launched_q <= launched_d;
            cnt_q      <= cnt_d;
        end
    end

    // ---------------- control FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (bus.enable) state_d = init_done_q ? S_WAIT_TICK : S_INIT_FMT;
            S_INIT_FMT:  if (done_q) state_d = bus.enable ? S_INIT_PWR : S_IDLE;
            S_INIT_PWR:  if (done_q) state_d = bus.enable ? S_WAIT_TICK : S_IDLE;
            S_WAIT_TICK: begin
                if (!bus.enable)  state_d = S_IDLE;
                else if (tick)    state_d = S_READ_X;
            end
            S_READ_X:    if (done_q) state_d = S_UPDATE;
            S_UPDATE:    state_d = S_WAIT_TICK;
            default:     state_d = S_IDLE;
        endcase

        launched_d = launched_q;
        if (done_q)     launched_d = 1'b0;
        else if (start) launched_d = 1'b1;

        // Sample timer runs only while periodic reads are active; ticks during READ_X are lost.
        cnt_d = cnt_q;
        if (state_q inside {S_WAIT_TICK, S_READ_X, S_UPDATE})
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // ---------------- control FSM: outputs ----------------
    always_comb begin
        start_word = 24'h000000;
        start_bits = 5'd15;
        unique case (state_q)
            S_INIT_FMT: start_word = 24'h310000;
            S_INIT_PWR: start_word = 24'h2D0800;
            S_READ_X: begin
                start_word = 24'hF20000;
                start_bits = 5'd23;
            end
            default: ;
        endcase
        start = (state_q inside {S_INIT_FMT, S_INIT_PWR, S_READ_X})
                && (eng_q == E_IDLE) && !launched_q;
    end

    // ---------------- SPI bit engine ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_q  <= E_IDLE;
            div_q  <= '0;
            bits_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            cs_n_q <= 1'b1;
            sclk_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            eng_q  <= eng_d;
            div_q  <= div_d;
            bits_q <= bits_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            cs_n_q <= cs_n_d;
            sclk_q <= sclk_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        eng_d  = eng_q;
        div_d  = div_q;
        bits_d = bits_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        cs_n_d = cs_n_q;
        sclk_d = sclk_q;
        done_d = 1'b0;
        unique case (eng_q)
            E_IDLE: if (start) begin
                eng_d  = E_LEAD;
                cs_n_d = 1'b0;
                tx_d   = start_word;
                bits_d = start_bits;
                div_d  = '0;
            end
            E_LEAD: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    eng_d  = E_LOW;
                    sclk_d = 1'b0;
                    div_d  = '0;
                end
            end
            E_LOW: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    eng_d  = E_HIGH;
                    sclk_d = 1'b1;
                    div_d  = '0;
                    // Skip DATAX1[7:2]: the shifter then ends holding {DATAX0, DATAX1[1:0]}.
                    if (!(bits_q inside {[5'd2:5'd7]}))
                        rx_d = {rx_q[8:0], bus.spi_miso};
                end
            end
            E_HIGH: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d = '0;
                    if (bits_q == 5'd0) begin
                        eng_d = E_TAIL;
                    end else begin
                        eng_d  = E_LOW;
                        bits_d = bits_q - 5'd1;
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[22:0], 1'b0};
                    end
                end
            end
            E_TAIL: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    eng_d  = E_GAP;
                    cs_n_d = 1'b1;
                    done_d = 1'b1;
                    div_d  = '0;
                end
            end
            E_GAP: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == DIV_W'(CS_GAP - 1)) begin
                    eng_d = E_IDLE;
                    div_d = '0;
                end
            end
            default: eng_d = E_IDLE;
        endcase
    end

    assign raw_x = {rx_q[1:0], rx_q[9:2]};

    // ---------------- sample output ----------------
`ifdef ACCEL_AVG_EN
    logic [9:0]  win [4];
    logic [11:0] win_sum;
    logic [1:0]  fill_q;

    assign win[0] = raw_x;

    for (genvar gi = 1; gi < 4; gi++) begin : g_hist
        logic [9:0] h_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                   h_q <= '0;
            else if (state_q == S_UPDATE) h_q <= win[gi-1];
        end
        assign win[gi] = h_q;
    end

    always_comb begin
        win_sum = '0;
        for (int i = 0; i < 4; i++)
            win_sum = win_sum + {{2{win[i][9]}}, win[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     fill_q <= '0;
        else if (state_q == S_UPDATE && fill_q != 2'd3) fill_q <= fill_q + 2'd1;
    end

    // Dropping the two LSBs of the signed sum is the floor division by four.
    always_comb begin
        a_num_d   = a_num_q;
        a_valid_d = 1'b0;
        if (state_q == S_UPDATE) begin
            a_num_d   = win_sum[11:2];
            a_valid_d = (fill_q == 2'd3);
        end
    end
`else
    always_comb begin
        a_num_d   = a_num_q;
        a_valid_d = 1'b0;
        if (state_q == S_UPDATE) begin
            a_num_d   = raw_x;
            a_valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_num_q     <= '0;
            a_valid_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            a_num_q   <= a_num_d;
            a_valid_q <= a_valid_d;
            if (state_q == S_INIT_PWR && done_q)
                init_done_q <= 1'b1;
        end
    end

    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_sclk  = sclk_q;
    assign bus.spi_mosi  = cs_n_q | tx_q[23];
    assign bus.a_num     = a_num_q;
    assign bus.a_valid   = a_valid_q;
    assign bus.init_done = init_done_q;
    assign bus.busy      = (eng_q != E_IDLE);
endmodule
